// File: rtl/axi4_sram_slave.sv
// AXI4 slave bridging single-beat reads/writes onto an SRAM-style request port.
// Bursts get no memory access: reads are drained with SLVERR beats, writes are swallowed and answered with SLVERR.
module axi4_sram_slave (
   input  logic        ACLK,
   input  logic        ARESETn,
   input  logic        AWID,
   input  logic [31:0] AWADDR,
   input  logic [7:0]  AWLEN,
   input  logic        AWVALID,
   output logic        AWREADY,
   input  logic [31:0] WDATA,
   input  logic [3:0]  WSTRB,
   input  logic        WLAST,
   input  logic        WVALID,
   output logic        WREADY,
   output logic        BID,
   output logic [1:0]  BRESP,
   output logic        BVALID,
   input  logic        BREADY,
   output logic        BUSER,
   input  logic        ARID,
   input  logic [31:0] ARADDR,
   input  logic [7:0]  ARLEN,
   input  logic        ARVALID,
   output logic        ARREADY,
   output logic        RID,
   output logic [31:0] RDATA,
   output logic [1:0]  RRESP,
   output logic        RLAST,
   output logic        RVALID,
   input  logic        RREADY,
   output logic        RUSER,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_c_en,
   output logic        mem_w_en,
   output logic [3:0]  mem_b_en,
   input  logic [31:0] mem_rdata,
   input  logic        mem_error,
   input  logic        mem_stall,
   output logic [2:0]  dbg_state_o
);

   // Handshakes: a transfer happens on a rising ACLK edge where VALID and READY are both high;
   // every VALID here is a flop, READYs are decoded from state (and the competing VALIDs in IDLE).
   typedef enum logic [2:0] {
      ST_IDLE, ST_W_DATA, ST_MEM_REQ, ST_MEM_WAIT, ST_R_RESP, ST_B_RESP, ST_ERR_DRAIN
   } state_t;

   localparam logic       GRANT_RD    = 1'b0;
   localparam logic       GRANT_WR    = 1'b1;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   state_t      state_q;
   logic        last_grant_q;
   logic        is_write_q;
   logic        id_q;
   logic [31:0] addr_q;
   logic [7:0]  cnt_q;
   logic        rvalid_q, rlast_q, rid_q;
   logic [31:0] rdata_q;
   logic [1:0]  rresp_q;
   logic        bvalid_q, bid_q;
   logic [1:0]  bresp_q;
   logic        mem_c_en_q, mem_w_en_q;
   logic [31:0] mem_addr_q, mem_wdata_q;
   logic [3:0]  mem_b_en_q;

   logic rd_win, wr_win;

   // Round robin: a contested IDLE cycle goes to the channel that did not win last.
   assign rd_win  = ARVALID && (!AWVALID || (last_grant_q == GRANT_WR));
   assign wr_win  = AWVALID && (!ARVALID || (last_grant_q == GRANT_RD));
   assign ARREADY = ARESETn && (state_q == ST_IDLE) && rd_win;
   assign AWREADY = ARESETn && (state_q == ST_IDLE) && wr_win;
   assign WREADY  = (state_q == ST_W_DATA) || ((state_q == ST_ERR_DRAIN) && is_write_q);

   assign RVALID      = rvalid_q;
   assign RLAST       = rlast_q;
   assign RID         = rid_q;
   assign RDATA       = rdata_q;
   assign RRESP       = rresp_q;
   assign RUSER       = 1'b0;
   assign BVALID      = bvalid_q;
   assign BID         = bid_q;
   assign BRESP       = bresp_q;
   assign BUSER       = 1'b0;
   assign mem_c_en    = mem_c_en_q;
   assign mem_w_en    = mem_w_en_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_b_en    = mem_b_en_q;
   assign dbg_state_o = state_q;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q      <= ST_IDLE;
         last_grant_q <= GRANT_WR;
         is_write_q   <= 1'b0;
         id_q         <= 1'b0;
         addr_q       <= '0;
         cnt_q        <= '0;
         rvalid_q     <= 1'b0;
         rlast_q      <= 1'b0;
         rid_q        <= 1'b0;
         rdata_q      <= '0;
         rresp_q      <= RESP_OKAY;
         bvalid_q     <= 1'b0;
         bid_q        <= 1'b0;
         bresp_q      <= RESP_OKAY;
         mem_c_en_q   <= 1'b0;
         mem_w_en_q   <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_b_en_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ARREADY) begin
                  last_grant_q <= GRANT_RD;
                  is_write_q   <= 1'b0;
                  id_q         <= ARID;
                  addr_q       <= ARADDR;
                  cnt_q        <= ARLEN;
                  if (ARLEN == 8'd0) begin
                     state_q     <= ST_MEM_REQ;
                     mem_c_en_q  <= 1'b1;
                     mem_w_en_q  <= 1'b0;
                     mem_addr_q  <= ARADDR;
                     mem_wdata_q <= '0;
                     mem_b_en_q  <= 4'hF;
                  end else begin
                     state_q  <= ST_ERR_DRAIN;
                     rvalid_q <= 1'b1;
                     rlast_q  <= 1'b0;
                     rid_q    <= ARID;
                     rdata_q  <= '0;
                     rresp_q  <= RESP_SLVERR;
                  end
               end else if (AWREADY) begin
                  last_grant_q <= GRANT_WR;
                  is_write_q   <= 1'b1;
                  id_q         <= AWID;
                  addr_q       <= AWADDR;
                  cnt_q        <= AWLEN;
                  state_q      <= (AWLEN == 8'd0) ? ST_W_DATA : ST_ERR_DRAIN;
               end
            end
            ST_W_DATA: begin
               if (WVALID) begin
                  state_q     <= ST_MEM_REQ;
                  mem_c_en_q  <= 1'b1;
                  mem_w_en_q  <= 1'b1;
                  mem_addr_q  <= addr_q;
                  mem_wdata_q <= WDATA;
                  mem_b_en_q  <= WSTRB;
               end
            end
            ST_MEM_REQ: begin
               if (!mem_stall) begin
                  state_q     <= ST_MEM_WAIT;
                  mem_c_en_q  <= 1'b0;
                  mem_w_en_q  <= 1'b0;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= '0;
                  mem_b_en_q  <= '0;
               end
            end
            ST_MEM_WAIT: begin
               if (!mem_stall) begin
                  if (is_write_q) begin
                     state_q  <= ST_B_RESP;
                     bvalid_q <= 1'b1;
                     bid_q    <= id_q;
                     bresp_q  <= mem_error ? RESP_SLVERR : RESP_OKAY;
                  end else begin
                     state_q  <= ST_R_RESP;
                     rvalid_q <= 1'b1;
                     rlast_q  <= 1'b1;
                     rid_q    <= id_q;
                     rdata_q  <= mem_rdata;
                     rresp_q  <= mem_error ? RESP_SLVERR : RESP_OKAY;
                  end
               end
            end
            ST_R_RESP: begin
               if (RREADY) begin
                  state_q  <= ST_IDLE;
                  rvalid_q <= 1'b0;
                  rlast_q  <= 1'b0;
                  rid_q    <= 1'b0;
                  rdata_q  <= '0;
                  rresp_q  <= RESP_OKAY;
               end
            end
            ST_B_RESP: begin
               if (BREADY) begin
                  state_q  <= ST_IDLE;
                  bvalid_q <= 1'b0;
                  bid_q    <= 1'b0;
                  bresp_q  <= RESP_OKAY;
               end
            end
            ST_ERR_DRAIN: begin
               // cnt_q holds the beats still owed after the current one.
               if (is_write_q) begin
                  if (WVALID && WLAST) begin
                     state_q  <= ST_B_RESP;
                     bvalid_q <= 1'b1;
                     bid_q    <= id_q;
                     bresp_q  <= RESP_SLVERR;
                  end
               end else if (RREADY) begin
                  if (cnt_q == 8'd0) begin
                     state_q  <= ST_IDLE;
                     rvalid_q <= 1'b0;
                     rlast_q  <= 1'b0;
                     rid_q    <= 1'b0;
                     rresp_q  <= RESP_OKAY;
                  end else begin
                     cnt_q   <= cnt_q - 8'd1;
                     rlast_q <= (cnt_q == 8'd1);
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Bench for axi4_sram_slave: directed scenarios then random single/burst traffic,
// with a byte-addressed SRAM responder and an independent expected-memory model.
module tb_axi4_sram_slave;

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic        AWID, ARID;
   logic [31:0] AWADDR, ARADDR, WDATA;
   logic [7:0]  AWLEN, ARLEN;
   logic        AWVALID, ARVALID, WVALID, WLAST, RREADY, BREADY;
   logic [3:0]  WSTRB;
   logic        AWREADY, ARREADY, WREADY;
   logic        BID, BVALID, BUSER, RID, RLAST, RVALID, RUSER;
   logic [1:0]  BRESP, RRESP;
   logic [31:0] RDATA, mem_addr, mem_wdata;
   logic        mem_c_en, mem_w_en;
   logic [3:0]  mem_b_en;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_stall = 1'b0;
   logic        mem_error;
   logic [2:0]  dbg_state;

   axi4_sram_slave dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY), .BUSER(BUSER),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .RUSER(RUSER),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_c_en(mem_c_en), .mem_w_en(mem_w_en),
      .mem_b_en(mem_b_en), .mem_rdata(mem_rdata), .mem_error(mem_error), .mem_stall(mem_stall),
      .dbg_state_o(dbg_state)
   );

   always #5 ACLK = ~ACLK;

   int total = 0;
   int bad   = 0;
   int stall_req_n  = 0;
   int stall_wait_n = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        we;
      int          cycles;
      logic        stable;
   } req_t;

   req_t        got_q[$];
   req_t        cur;
   int          req_cyc = 0;
   int          st_cnt  = 0;
   logic        in_wait = 1'b0;
   logic [31:0] sram[logic [31:0]];
   logic [31:0] exp_mem[logic [31:0]];

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [31:0] a);
      return exp_mem.exists(a) ? exp_mem[a] : dflt(a);
   endfunction

   // SRAM responder: stalls each request stall_req_n cycles, then the response stall_wait_n cycles.
   always @(negedge ACLK) begin
      if (!ARESETn) begin
         st_cnt = 0; in_wait = 1'b0; req_cyc = 0; mem_stall = 1'b0;
      end else if (mem_c_en) begin
         if (req_cyc == 0) begin
            cur.addr = mem_addr; cur.wdata = mem_wdata; cur.be = mem_b_en;
            cur.we = mem_w_en; cur.stable = 1'b1;
         end else if ({cur.addr, cur.wdata, cur.be, cur.we} != {mem_addr, mem_wdata, mem_b_en, mem_w_en}) begin
            cur.stable = 1'b0;
         end
         req_cyc++;
         if (st_cnt < stall_req_n) begin
            mem_stall = 1'b1; st_cnt++;
         end else begin
            mem_stall = 1'b0; st_cnt = 0; in_wait = 1'b1;
            cur.cycles = req_cyc; req_cyc = 0;
            got_q.push_back(cur);
            if (cur.we)
               sram[cur.addr] = merge(sram.exists(cur.addr) ? sram[cur.addr] : dflt(cur.addr),
                                      cur.wdata, cur.be);
            else
               mem_rdata = sram.exists(cur.addr) ? sram[cur.addr] : dflt(cur.addr);
         end
      end else if (in_wait) begin
         if (st_cnt < stall_wait_n) begin
            mem_stall = 1'b1; st_cnt++;
         end else begin
            mem_stall = 1'b0; st_cnt = 0; in_wait = 1'b0;
         end
      end else begin
         mem_stall = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ready"}, {29'd0, ARREADY, AWREADY, WREADY}, 32'd0);
      chk({tag, "_valid"}, {27'd0, BVALID, RVALID, RLAST, mem_c_en, mem_w_en}, 32'd0);
      chk({tag, "_rdata"}, RDATA, 32'd0);
      chk({tag, "_resp"}, {22'd0, RID, BID, RRESP, BRESP, mem_b_en}, 32'd0);
      chk({tag, "_maddr"}, mem_addr, 32'd0);
      chk({tag, "_mwdata"}, mem_wdata, 32'd0);
   endtask

   task automatic drive_idle();
      ARVALID = 0; AWVALID = 0; WVALID = 0; WLAST = 0; RREADY = 0; BREADY = 0;
      ARID = 0; AWID = 0; ARADDR = 0; AWADDR = 0; ARLEN = 0; AWLEN = 0; WDATA = 0; WSTRB = 0;
   endtask

   task automatic apply_reset(input string tag);
      ARESETn = 1'b0;
      drive_idle();
      repeat (2) @(posedge ACLK);
      #1 chk_zero(tag);
      @(negedge ACLK) ARESETn = 1'b1;
      @(posedge ACLK); #1;
      got_q.delete();
   endtask

   task automatic set_ar(input logic id, input logic [31:0] a, input logic [7:0] len);
      ARID = id; ARADDR = a; ARLEN = len; ARVALID = 1'b1;
   endtask

   task automatic set_aw(input logic id, input logic [31:0] a, input logic [7:0] len);
      AWID = id; AWADDR = a; AWLEN = len; AWVALID = 1'b1;
   endtask

   task automatic wait_ar();
      int t = 0;
      @(negedge ACLK);
      while (!ARREADY && t < 50) begin @(negedge ACLK); t++; end
      chk("ar_handshake", {31'd0, ARREADY}, 32'd1);
      @(posedge ACLK); #1 ARVALID = 1'b0;
   endtask

   task automatic wait_aw();
      int t = 0;
      @(negedge ACLK);
      while (!AWREADY && t < 50) begin @(negedge ACLK); t++; end
      chk("aw_handshake", {31'd0, AWREADY}, 32'd1);
      @(posedge ACLK); #1 AWVALID = 1'b0;
   endtask

   task automatic send_w(input logic [7:0] len, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b <= int'(len); b++) begin
         int t = 0;
         WDATA = (b == 0) ? d : $urandom; WSTRB = s; WLAST = (b == int'(len)); WVALID = 1'b1;
         @(negedge ACLK);
         while (!WREADY && t < 50) begin @(negedge ACLK); t++; end
         chk("w_handshake", {31'd0, WREADY}, 32'd1);
         @(posedge ACLK); #1;
      end
      WVALID = 1'b0; WLAST = 1'b0;
   endtask

   task automatic get_r(input logic id, input logic [31:0] a, input logic [7:0] len,
                        input logic err, input bit rnd);
      int beats = 0;
      int t = 0;
      int n = int'(len) + 1;
      while (beats < n && t < 300) begin
         RREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge ACLK);
         if (RVALID && RREADY) begin
            if (len == 8'd0) begin
               chk("r_data", RDATA, exp_rd(a));
               chk("r_resp", {30'd0, RRESP}, err ? 32'd2 : 32'd0);
               chk("r_last", {31'd0, RLAST}, 32'd1);
            end else begin
               chk("rburst_data", RDATA, 32'd0);
               chk("rburst_resp", {30'd0, RRESP}, 32'd2);
               chk("rburst_last", {31'd0, RLAST}, (beats == n - 1) ? 32'd1 : 32'd0);
            end
            chk("r_id", {31'd0, RID}, {31'd0, id});
            beats++;
         end
         @(posedge ACLK); #1; t++;
      end
      RREADY = 1'b0;
      chk("r_beat_count", beats, n);
      @(negedge ACLK);
      chk("r_quiet_after", {31'd0, RVALID}, 32'd0);
      @(posedge ACLK); #1;
   endtask

   task automatic get_b(input logic id, input logic [1:0] resp, input bit rnd);
      int got = 0;
      int t = 0;
      while (got == 0 && t < 300) begin
         BREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge ACLK);
         if (BVALID && BREADY) begin
            chk("b_id", {31'd0, BID}, {31'd0, id});
            chk("b_resp", {30'd0, BRESP}, {30'd0, resp});
            got = 1;
         end
         @(posedge ACLK); #1; t++;
      end
      BREADY = 1'b0;
      chk("b_handshake", got, 1);
      @(negedge ACLK);
      chk("b_quiet_after", {31'd0, BVALID}, 32'd0);
      @(posedge ACLK); #1;
   endtask

   task automatic check_reqs(input int n_exp, input logic we, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] be, input int cyc);
      req_t r;
      chk("req_count", got_q.size(), n_exp);
      if (n_exp == 1 && got_q.size() > 0) begin
         r = got_q.pop_front();
         chk("req_addr", r.addr, a);
         chk("req_we", {31'd0, r.we}, {31'd0, we});
         chk("req_be", {28'd0, r.be}, {28'd0, be});
         if (we) chk("req_wdata", r.wdata, wd);
         chk("req_cycles", r.cycles, cyc);
         chk("req_stable", {31'd0, r.stable}, 32'd1);
      end
      got_q.delete();
   endtask

   task automatic do_read(input logic id, input logic [31:0] a, input logic [7:0] len,
                          input logic err, input int sr, input int sw, input bit rnd);
      mem_error = err; stall_req_n = sr; stall_wait_n = sw;
      set_ar(id, a, len);
      wait_ar();
      get_r(id, a, len, err, rnd);
      if (len == 8'd0) check_reqs(1, 1'b0, a, 32'd0, 4'hF, sr + 1);
      else             check_reqs(0, 1'b0, a, 32'd0, 4'hF, 0);
   endtask

   task automatic do_write(input logic id, input logic [31:0] a, input logic [7:0] len,
                           input logic [31:0] d, input logic [3:0] s, input logic err,
                           input int sr, input int sw, input bit rnd);
      mem_error = err; stall_req_n = sr; stall_wait_n = sw;
      set_aw(id, a, len);
      wait_aw();
      send_w(len, d, s);
      get_b(id, (len != 8'd0 || err) ? 2'b10 : 2'b00, rnd);
      if (len == 8'd0) begin
         check_reqs(1, 1'b1, a, d, s, sr + 1);
         exp_mem[a] = merge(exp_rd(a), d, s);
      end else begin
         check_reqs(0, 1'b1, a, d, s, 0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      mem_error = 1'b0;
      apply_reset("reset");

      // Single read at 0x100 returning a known word.
      sram[32'h100] = 32'hDEADBEEF;
      exp_mem[32'h100] = 32'hDEADBEEF;
      do_read(1'b0, 32'h100, 8'd0, 1'b0, 0, 0, 1'b0);

      // Strobed write held through three stall cycles, then read back with random ready.
      do_write(1'b0, 32'h200, 8'd0, 32'h12345678, 4'h3, 1'b0, 3, 0, 1'b0);
      do_read(1'b1, 32'h200, 8'd0, 1'b0, 1, 2, 1'b1);

      // Contested address channels straight out of reset: read first, then write.
      apply_reset("reset2");
      mem_error = 1'b0; stall_req_n = 0; stall_wait_n = 0;
      set_aw(1'b1, 32'h300, 8'd0);
      set_ar(1'b0, 32'h304, 8'd0);
      @(negedge ACLK);
      chk("contest1_arready", {31'd0, ARREADY}, 32'd1);
      chk("contest1_awready", {31'd0, AWREADY}, 32'd0);
      @(posedge ACLK); #1 ARVALID = 1'b0; AWVALID = 1'b0;
      get_r(1'b0, 32'h304, 8'd0, 1'b0, 1'b0);
      check_reqs(1, 1'b0, 32'h304, 32'd0, 4'hF, 1);
      set_aw(1'b1, 32'h300, 8'd0);
      set_ar(1'b0, 32'h308, 8'd0);
      @(negedge ACLK);
      chk("contest2_awready", {31'd0, AWREADY}, 32'd1);
      chk("contest2_arready", {31'd0, ARREADY}, 32'd0);
      @(posedge ACLK); #1 AWVALID = 1'b0; ARVALID = 1'b0;
      mem_error = 1'b1;
      send_w(8'd0, 32'hCAFEF00D, 4'hF);
      get_b(1'b1, 2'b10, 1'b0);
      check_reqs(1, 1'b1, 32'h300, 32'hCAFEF00D, 4'hF, 1);
      exp_mem[32'h300] = 32'hCAFEF00D;

      // Unsupported bursts.
      do_read(1'b1, 32'h400, 8'd3, 1'b0, 0, 0, 1'b1);
      do_write(1'b0, 32'h500, 8'd2, 32'h11111111, 4'hF, 1'b0, 0, 0, 1'b0);

      // Reset while the read response is stalled: nothing may come out afterwards.
      mem_error = 1'b0; stall_req_n = 0; stall_wait_n = 6;
      set_ar(1'b1, 32'h600, 8'd0);
      wait_ar();
      t = 0;
      @(negedge ACLK);
      while (got_q.size() == 0 && t < 50) begin @(negedge ACLK); t++; end
      chk("midrst_req_seen", got_q.size(), 1);
      got_q.delete();
      @(posedge ACLK); #2 ARESETn = 1'b0;
      #1 chk_zero("midrst");
      @(negedge ACLK); @(negedge ACLK) ARESETn = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge ACLK);
         chk("midrst_no_rvalid", {31'd0, RVALID}, 32'd0);
         chk("midrst_no_mem", {31'd0, mem_c_en}, 32'd0);
      end
      chk("midrst_no_new_req", got_q.size(), 0);
      @(posedge ACLK); #1;
      do_read(1'b0, 32'h600, 8'd0, 1'b0, 0, 0, 1'b0);

      // Random mix of reads, writes, bursts, stalls and errors.
      for (int k = 0; k < 40; k++) begin
         logic [31:0] a;
         logic [7:0]  len;
         logic        err;
         a   = 32'h700 + 32'(4 * $urandom_range(0, 7));
         len = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 4)) : 8'd0;
         err = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 1)
            do_write(1'($urandom_range(0, 1)), a, len, $urandom, 4'($urandom_range(0, 15)), err,
                     $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
         else
            do_read(1'($urandom_range(0, 1)), a, len, err,
                    $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi4_sram_slave.md
AXI4_SRAM_SLAVE -- requirements
Module: axi4_sram_slave

Interface
REQ-001 Parameter: none; all widths fixed (32-bit address/data, 1-bit IDs, 4-bit strobes).
REQ-002 ACLK  in  1  sole clock; all state rises on posedge ACLK.
REQ-003 ARESETn  in  1  asynchronous, active-low reset.
REQ-004 AWID in 1, AWADDR in 32, AWLEN in 8, AWVALID in 1, AWREADY out 1  write address channel; other AW sideband inputs ignored.
REQ-005 WDATA in 32, WSTRB in 4, WLAST in 1, WVALID in 1, WREADY out 1  write data channel.
REQ-006 BID out 1, BRESP out 2, BVALID out 1, BREADY in 1  write response channel; BUSER tied 0.
REQ-007 ARID in 1, ARADDR in 32, ARLEN in 8, ARVALID in 1, ARREADY out 1  read address channel; other AR sideband inputs ignored.
REQ-008 RID out 1, RDATA out 32, RRESP out 2, RLAST out 1, RVALID out 1, RREADY in 1  read data channel; RUSER tied 0.
REQ-009 mem_addr out 32, mem_wdata out 32, mem_c_en out 1, mem_w_en out 1, mem_b_en out 4  SRAM-style request.
REQ-010 mem_rdata in 32, mem_error in 1, mem_stall in 1  SRAM-style response.

Function
REQ-011 FSM states: IDLE, W_DATA, MEM_REQ, MEM_WAIT, R_RESP, B_RESP, ERR_DRAIN; one transaction outstanding at a time.
REQ-012 IDLE: ARREADY/AWREADY asserted only for the granted channel; handshake captures ID, address, length into registers.
REQ-013 Both ARVALID and AWVALID high in IDLE: round-robin grant via 1-bit last_grant register, reset value "write" so first contest goes to read.
REQ-014 AW accepted with AWLEN=0 -> W_DATA; WREADY=1 there; W handshake captures WDATA/WSTRB -> MEM_REQ.
REQ-015 AR accepted with ARLEN=0 -> MEM_REQ directly.
REQ-016 MEM_REQ: mem_c_en=1, mem_w_en=1 for write/0 for read, mem_addr=captured address, mem_wdata/mem_b_en=captured data/strobe (mem_b_en=4'hF on reads); held stable while mem_stall=1.
REQ-017 Request accepted in the cycle mem_c_en=1 and mem_stall=0 -> MEM_WAIT; mem_c_en=0 in MEM_WAIT.
REQ-018 MEM_WAIT: mem_rdata and mem_error sampled into registers the first cycle mem_stall=0 -> R_RESP (read) or B_RESP (write).
REQ-019 Response code: mem_error=1 -> 2'b10 (SLVERR), else 2'b00 (OKAY).
REQ-020 R_RESP: RVALID=1, RLAST=1, RID=captured ID, RDATA/RRESP from registers, all stable until RREADY; handshake -> IDLE.
REQ-021 B_RESP: BVALID=1, BID=captured ID, BRESP from register, stable until BREADY; handshake -> IDLE.
REQ-022 AxLEN!=0 (burst unsupported): no SRAM access; beat counter loaded with AxLEN.
REQ-023 Burst read -> ERR_DRAIN issues AxLEN+1 R beats, RRESP=SLVERR, RDATA=0, RLAST only on final beat, counter decrements per handshake -> IDLE.
REQ-024 Burst write -> ERR_DRAIN holds WREADY=1, discards beats until WLAST handshake, then B_RESP with SLVERR.
REQ-025 No READY asserted in any state not listed above; VALIDs never depend combinationally on READYs.
REQ-026 Unused mem_* outputs driven 0 outside MEM_REQ (mem_addr, mem_wdata, mem_b_en zero-gated).

Reset
REQ-027 ARESETn low: FSM -> IDLE; last_grant=write; counter, captured regs =0; all VALID/READY outputs, mem_c_en, mem_w_en =0; data/response outputs =0.
REQ-028 Reset mid-transaction abandons it with no response and no further SRAM request; ARREADY/AWREADY may assert the first cycle after release.

Verification
REQ-029 AR addr 0x100, ARLEN=0, mem_rdata=0xDEADBEEF, no stall -> one mem_c_en read pulse at 0x100, RVALID with 0xDEADBEEF, OKAY, RLAST=1.
REQ-030 AW 0x200 then W 0x12345678 WSTRB=4'h3, mem_stall high 3 cycles -> mem_c_en/mem_w_en held 4 cycles, mem_b_en=4'h3, then BRESP OKAY.
REQ-031 Simultaneous AR and AW twice from reset -> read granted first, write second; mem_error=1 on write -> BRESP=2'b10.
REQ-032 ARLEN=3, ARID=1 -> zero mem_c_en pulses, 4 R beats SLVERR RID=1, RLAST only on 4th; RREADY toggling preserves beat count.
REQ-033 AWLEN=2 with 3 W beats -> no SRAM write, BRESP=SLVERR after WLAST beat.
REQ-034 ARESETn pulsed during MEM_WAIT -> all outputs 0 immediately, no R beat, clean read succeeds afterwards.
